// File: rtl/layer_region_allocator.sv
// Bump allocator that carves model, weight, bias and scratch regions for each layer
// descriptor out of a memory pool and streams them one at a time over valid/ready.
module layer_region_allocator #(
  parameter int ADDR_W    = 23,
  parameter int DIM_W     = 16,
  parameter int W_HDR     = 4,
  parameter int V_HDR     = 3,
  parameter int POOL_BASE = 0,
  parameter int POOL_SIZE = 2**22
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [7:0]        lyr_opcode,
  input  logic [DIM_W-1:0]  lyr_insize,
  input  logic [DIM_W-1:0]  lyr_outsize,
  input  logic              train_en,
  output logic              asn_valid,
  input  logic              asn_ready,
  output logic [2:0]        asn_kind,
  output logic [ADDR_W-1:0] asn_begin,
  output logic [ADDR_W-1:0] asn_end,
  output logic              done,
  output logic              err_oflow,
  output logic              err_opcode,
  output logic              err_seq,
  output logic [ADDR_W-1:0] avail_ptr
);

  // One spare bit above the widest operand so a sum can never wrap past the limit.
  localparam int AW = ((ADDR_W > 2*DIM_W) ? ADDR_W : 2*DIM_W) + 1;
  localparam logic [AW-1:0] LIMIT = AW'(POOL_BASE) + AW'(POOL_SIZE);

  localparam logic [1:0] OP_MODEL   = 2'd0;
  localparam logic [1:0] OP_LAYER   = 2'd1;
  localparam logic [1:0] OP_RELEASE = 2'd2;
  localparam logic [7:0] LYR_LINEAR = 8'd1;
  localparam logic [7:0] LYR_RELU   = 8'd3;

  localparam logic [2:0] K_MODEL   = 3'd0;
  localparam logic [2:0] K_WEIGHT  = 3'd1;
  localparam logic [2:0] K_WGRAD   = 3'd2;
  localparam logic [2:0] K_BIAS    = 3'd3;
  localparam logic [2:0] K_BGRAD   = 3'd4;
  localparam logic [2:0] K_SCRATCH = 3'd5;

  typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

  state_t              state, state_nxt;
  logic [1:0]          op_q;
  logic [7:0]          lop_q;
  logic [DIM_W-1:0]    in_q, out_q, prev_out;
  logic                train_q;
  logic [ADDR_W-1:0]   cmd_len_q;
  logic [AW-1:0]       len_w, len_b, len_g;
  logic [6:0]          mask;
  logic [ADDR_W-1:0]   model_ptr, model_end;
  logic                model_valid;

  logic                is_linear, is_relu, bad_op, seq_err;
  logic [DIM_W-1:0]    eff_in, eff_out;
  logic [2*DIM_W-1:0]  prod;
  logic [2:0]          cur_kind;
  logic                model_src, oflow, emit_ok, hs, last;
  logic [AW-1:0]       cur_len, base, reg_end, bound;

  assign is_linear = (op_q == OP_LAYER) && (lop_q == LYR_LINEAR);
  assign is_relu   = (op_q == OP_LAYER) && (lop_q == LYR_RELU);
  assign bad_op    = (op_q == 2'd3) || ((op_q == OP_LAYER) && !is_linear && !is_relu);
  assign seq_err   = is_linear && !model_valid;
  // RELU is shape-preserving: both sides take the previous layer's output size.
  assign eff_in    = is_relu ? prev_out : in_q;
  assign eff_out   = is_relu ? prev_out : out_q;
  assign prod      = {{DIM_W{1'b0}}, eff_in} * {{DIM_W{1'b0}}, eff_out};

  // The emit list is a bitmask indexed by kind; kind order equals emission order.
  always_comb begin
    cur_kind = K_MODEL;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i]) cur_kind = 3'(i);
    end
  end

  always_comb begin
    case (cur_kind)
      K_MODEL, K_WEIGHT, K_WGRAD: cur_len = len_w;
      K_BIAS, K_BGRAD, K_SCRATCH: cur_len = len_b;
      default:                    cur_len = len_g;
    endcase
  end

  assign model_src = (cur_kind == K_WEIGHT) || (cur_kind == K_BIAS);
  assign base      = model_src ? AW'(model_ptr) : AW'(avail_ptr);
  assign reg_end   = base + cur_len;
  assign bound     = model_src ? AW'(model_end) : LIMIT;
  assign oflow     = reg_end > bound;
  assign emit_ok   = (state == EMIT) && (mask != 7'd0) && !oflow;
  assign hs        = emit_ok && asn_ready;
  assign last      = (mask & (mask - 7'd1)) == 7'd0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    asn_valid = 1'b0;
    asn_kind  = 3'd0;
    asn_begin = '0;
    asn_end   = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = CALC;
      end
      CALC: begin
        if (bad_op || seq_err || (op_q == OP_RELEASE)) state_nxt = DONE;
        else                                           state_nxt = EMIT;
      end
      EMIT: begin
        asn_valid = emit_ok;
        if (emit_ok) begin
          asn_kind  = cur_kind;
          asn_begin = base[ADDR_W-1:0];
          asn_end   = reg_end[ADDR_W-1:0];
        end
        if (!emit_ok || (hs && last)) state_nxt = DONE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      op_q        <= 2'd0;
      lop_q       <= 8'd0;
      in_q        <= '0;
      out_q       <= '0;
      train_q     <= 1'b0;
      cmd_len_q   <= '0;
      len_w       <= '0;
      len_b       <= '0;
      len_g       <= '0;
      mask        <= 7'd0;
      avail_ptr   <= ADDR_W'(POOL_BASE);
      model_ptr   <= '0;
      model_end   <= '0;
      model_valid <= 1'b0;
      prev_out    <= '0;
      err_oflow   <= 1'b0;
      err_opcode  <= 1'b0;
      err_seq     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            lop_q     <= lyr_opcode;
            in_q      <= lyr_insize;
            out_q     <= lyr_outsize;
            train_q   <= train_en;
            cmd_len_q <= cmd_len;
          end
        end
        CALC: begin
          len_w <= (op_q == OP_MODEL) ? AW'(cmd_len_q) : AW'(W_HDR) + AW'(prod);
          len_b <= AW'(V_HDR) + AW'(eff_out);
          len_g <= AW'(V_HDR) + AW'(eff_in);
          mask  <= 7'd0;
          if (op_q == OP_RELEASE) begin
            avail_ptr   <= ADDR_W'(POOL_BASE);
            model_valid <= 1'b0;
            prev_out    <= '0;
            err_oflow   <= 1'b0;
            err_opcode  <= 1'b0;
            err_seq     <= 1'b0;
          end else if (bad_op) begin
            err_opcode <= 1'b1;
          end else if (seq_err) begin
            err_seq <= 1'b1;
          end else if (op_q == OP_MODEL) begin
            mask <= 7'b0000001;
          end else if (is_linear) begin
            mask <= {train_q, 1'b1, train_q, 1'b1, train_q, 1'b1, 1'b0};
          end else begin
            mask <= {train_q, 1'b1, 5'b00000};
          end
        end
        EMIT: begin
          if ((mask != 7'd0) && oflow) begin
            err_oflow <= 1'b1;
            mask      <= 7'd0;
          end else if (hs) begin
            mask <= mask & (mask - 7'd1);
            if (model_src) model_ptr <= reg_end[ADDR_W-1:0];
            else           avail_ptr <= reg_end[ADDR_W-1:0];
            if (cur_kind == K_MODEL) begin
              model_ptr   <= avail_ptr;
              model_end   <= reg_end[ADDR_W-1:0];
              model_valid <= 1'b1;
            end
            if (last && is_linear) prev_out <= out_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_region_allocator.sv
// Directed bench for layer_region_allocator: a default-pool instance and a
// 130-word-pool instance driven by hand-computed command sequences.
module tb_layer_region_allocator;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [22:0] cmd_len = '0;
  logic [7:0]  lyr_opcode = 8'd0;
  logic [15:0] lyr_insize = '0, lyr_outsize = '0;
  logic        train_en = 1'b0, asn_ready = 1'b1;
  logic        cmd_valid_a = 1'b0, cmd_valid_b = 1'b0;

  logic        cmd_ready_a, asn_valid_a, done_a, err_oflow_a, err_opcode_a, err_seq_a;
  logic [2:0]  asn_kind_a;
  logic [22:0] asn_begin_a, asn_end_a, avail_ptr_a;
  logic        cmd_ready_b, asn_valid_b, done_b, err_oflow_b, err_opcode_b, err_seq_b;
  logic [2:0]  asn_kind_b;
  logic [22:0] asn_begin_b, asn_end_b, avail_ptr_b;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned q_k[$], q_b[$], q_e[$], q_c[$];
  int unsigned st_k[$], st_b[$], st_e[$];
  int done_cyc;

  always #5 clk = ~clk;

  layer_region_allocator dut_a (
    .clk(clk), .rst_l(rst_l), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .lyr_opcode(lyr_opcode),
    .lyr_insize(lyr_insize), .lyr_outsize(lyr_outsize), .train_en(train_en),
    .asn_valid(asn_valid_a), .asn_ready(asn_ready), .asn_kind(asn_kind_a),
    .asn_begin(asn_begin_a), .asn_end(asn_end_a), .done(done_a),
    .err_oflow(err_oflow_a), .err_opcode(err_opcode_a), .err_seq(err_seq_a),
    .avail_ptr(avail_ptr_a)
  );

  layer_region_allocator #(.POOL_SIZE(130)) dut_b (
    .clk(clk), .rst_l(rst_l), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .lyr_opcode(lyr_opcode),
    .lyr_insize(lyr_insize), .lyr_outsize(lyr_outsize), .train_en(train_en),
    .asn_valid(asn_valid_b), .asn_ready(asn_ready), .asn_kind(asn_kind_b),
    .asn_begin(asn_begin_b), .asn_end(asn_end_b), .done(done_b),
    .err_oflow(err_oflow_b), .err_opcode(err_opcode_b), .err_seq(err_seq_b),
    .avail_ptr(avail_ptr_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command at a negedge and record every handshaken region and the done cycle.
  task automatic issue(input bit sel, input logic [1:0] op, input logic [22:0] len,
                       input logic [7:0] lop, input logic [15:0] isz, input logic [15:0] osz,
                       input bit tr, input int stall_n);
    logic        v, d;
    logic [2:0]  k;
    logic [22:0] b, e;
    int          stall_left;
    stall_left = stall_n;
    q_k.delete(); q_b.delete(); q_e.delete(); q_c.delete();
    st_k.delete(); st_b.delete(); st_e.delete();
    done_cyc = -1;
    @(negedge clk);
    chk("cmd_ready_idle", sel ? cmd_ready_b : cmd_ready_a, 1);
    cmd_op = op; cmd_len = len; lyr_opcode = lop;
    lyr_insize = isz; lyr_outsize = osz; train_en = tr; asn_ready = 1'b1;
    if (sel) cmd_valid_b = 1'b1;
    else     cmd_valid_a = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid_a = 1'b0;
      cmd_valid_b = 1'b0;
      v = sel ? asn_valid_b : asn_valid_a;
      d = sel ? done_b : done_a;
      k = sel ? asn_kind_b : asn_kind_a;
      b = sel ? asn_begin_b : asn_begin_a;
      e = sel ? asn_end_b : asn_end_a;
      asn_ready = 1'b1;
      if (v) begin
        if (stall_left > 0 && k == 3'd3) begin
          asn_ready = 1'b0;
          stall_left--;
          st_k.push_back(k); st_b.push_back(b); st_e.push_back(e);
        end else begin
          q_k.push_back(k); q_b.push_back(b); q_e.push_back(e); q_c.push_back(c);
        end
      end
      if (d) begin
        done_cyc = c;
        break;
      end
    end
    asn_ready = 1'b1;
  endtask

  task automatic exp_reg(input string tag, input int i, input int unsigned k,
                         input int unsigned b, input int unsigned e, input int unsigned c);
    if (i < q_k.size()) begin
      chk($sformatf("%s[%0d].kind", tag, i), q_k[i], k);
      chk($sformatf("%s[%0d].begin", tag, i), q_b[i], b);
      chk($sformatf("%s[%0d].end", tag, i), q_e[i], e);
      chk($sformatf("%s[%0d].cycle", tag, i), q_c[i], c);
    end
  endtask

  initial begin
    int hits;
    repeat (3) @(negedge clk);
    chk("rst.asn_valid", asn_valid_a, 0);
    chk("rst.asn_kind", asn_kind_a, 0);
    chk("rst.asn_begin", asn_begin_a, 0);
    chk("rst.asn_end", asn_end_a, 0);
    chk("rst.done", done_a, 0);
    chk("rst.errs", {err_oflow_a, err_opcode_a, err_seq_a}, 0);
    chk("rst.avail_ptr", avail_ptr_a, 0);
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst.cmd_ready_a", cmd_ready_a, 1);
    chk("rst.cmd_ready_b", cmd_ready_b, 1);

    issue(0, 2'd0, 23'd100, 8'd0, 16'd0, 16'd0, 0, 0);
    chk("model.count", q_k.size(), 1);
    exp_reg("model", 0, 0, 0, 100, 2);
    chk("model.done_cyc", done_cyc, 3);
    chk("model.avail", avail_ptr_a, 100);

    issue(0, 2'd1, 23'd0, 8'd1, 16'd4, 16'd3, 1, 0);
    chk("lin.count", q_k.size(), 6);
    exp_reg("lin", 0, 1, 0, 16, 2);
    exp_reg("lin", 1, 2, 100, 116, 3);
    exp_reg("lin", 2, 3, 16, 22, 4);
    exp_reg("lin", 3, 4, 116, 122, 5);
    exp_reg("lin", 4, 5, 122, 128, 6);
    exp_reg("lin", 5, 6, 128, 135, 7);
    chk("lin.done_cyc", done_cyc, 8);
    chk("lin.avail", avail_ptr_a, 135);

    issue(0, 2'd1, 23'd0, 8'd3, 16'd9, 16'd9, 1, 0);
    chk("relu.count", q_k.size(), 2);
    exp_reg("relu", 0, 5, 135, 141, 2);
    exp_reg("relu", 1, 6, 141, 147, 3);
    chk("relu.done_cyc", done_cyc, 4);

    issue(0, 2'd1, 23'd0, 8'd1, 16'd4, 16'd3, 0, 0);
    chk("inf.count", q_k.size(), 3);
    exp_reg("inf", 0, 1, 22, 38, 2);
    exp_reg("inf", 1, 3, 38, 44, 3);
    exp_reg("inf", 2, 5, 147, 153, 4);
    chk("inf.done_cyc", done_cyc, 5);
    chk("inf.avail", avail_ptr_a, 153);

    issue(0, 2'd1, 23'd0, 8'd2, 16'd4, 16'd3, 1, 0);
    chk("badop.count", q_k.size(), 0);
    chk("badop.done_cyc", done_cyc, 2);
    chk("badop.err_opcode", err_opcode_a, 1);
    chk("badop.avail", avail_ptr_a, 153);

    issue(0, 2'd2, 23'd0, 8'd0, 16'd0, 16'd0, 0, 0);
    chk("rel.done_cyc", done_cyc, 2);
    chk("rel.err_opcode", err_opcode_a, 0);
    chk("rel.avail", avail_ptr_a, 0);

    issue(0, 2'd1, 23'd0, 8'd1, 16'd4, 16'd3, 1, 0);
    chk("seq.count", q_k.size(), 0);
    chk("seq.done_cyc", done_cyc, 2);
    chk("seq.err_seq", err_seq_a, 1);

    issue(0, 2'd3, 23'd5, 8'd0, 16'd0, 16'd0, 0, 0);
    chk("rsvd.count", q_k.size(), 0);
    chk("rsvd.err_opcode", err_opcode_a, 1);
    issue(0, 2'd2, 23'd0, 8'd0, 16'd0, 16'd0, 0, 0);
    chk("rel2.errs", {err_oflow_a, err_opcode_a, err_seq_a}, 0);

    issue(1, 2'd0, 23'd100, 8'd0, 16'd0, 16'd0, 0, 0);
    exp_reg("b.model", 0, 0, 0, 100, 2);
    issue(1, 2'd1, 23'd0, 8'd1, 16'd4, 16'd3, 1, 0);
    chk("b.lin.count", q_k.size(), 5);
    exp_reg("b.lin", 3, 4, 116, 122, 5);
    exp_reg("b.lin", 4, 5, 122, 128, 6);
    chk("b.lin.done_cyc", done_cyc, 8);
    chk("b.err_oflow", err_oflow_b, 1);
    chk("b.avail", avail_ptr_b, 128);
    issue(1, 2'd2, 23'd0, 8'd0, 16'd0, 16'd0, 0, 0);
    chk("b.rel.err_oflow", err_oflow_b, 0);
    chk("b.rel.avail", avail_ptr_b, 0);

    issue(0, 2'd0, 23'd100, 8'd0, 16'd0, 16'd0, 0, 0);
    issue(0, 2'd1, 23'd0, 8'd1, 16'd4, 16'd3, 1, 3);
    chk("stall.count", q_k.size(), 6);
    chk("stall.samples", st_k.size(), 3);
    for (int i = 0; i < st_k.size(); i++) begin
      chk($sformatf("stall[%0d].kind", i), st_k[i], 3);
      chk($sformatf("stall[%0d].begin", i), st_b[i], 16);
      chk($sformatf("stall[%0d].end", i), st_e[i], 22);
    end
    exp_reg("stall", 2, 3, 16, 22, 7);
    exp_reg("stall", 5, 6, 128, 135, 10);
    chk("stall.done_cyc", done_cyc, 11);
    chk("stall.avail", avail_ptr_a, 135);

    @(negedge clk);
    cmd_op = 2'd1; lyr_opcode = 8'd1; lyr_insize = 16'd4; lyr_outsize = 16'd3;
    train_en = 1'b1; asn_ready = 1'b1; cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    @(negedge clk);
    chk("mid.asn_valid_before", asn_valid_a, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("mid.asn_valid", asn_valid_a, 0);
    chk("mid.asn_begin", asn_begin_a, 0);
    chk("mid.avail", avail_ptr_a, 0);
    chk("mid.done", done_a, 0);
    @(negedge clk);
    rst_l = 1'b1;
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (asn_valid_a || done_a) hits++;
    end
    chk("mid.quiet", hits, 0);
    chk("mid.cmd_ready", cmd_ready_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
